// File: rtl/sram_stream_reader_if.sv
// Single-port SRAM access bundle shared by the feature-map SRAM and its initiators.
// W_req is an active-low write enable; R_data returns one cycle after a cs cycle.
interface sp_ram_intf;
  logic        cs;
  logic        oe;
  logic        W_req;
  logic [31:0] addr;
  logic [31:0] W_data;
  logic [31:0] R_data;

  modport master (output cs, oe, W_req, addr, W_data, input R_data);
  modport slave  (input cs, oe, W_req, addr, W_data, output R_data);
endinterface

// File: rtl/sram_stream_reader.sv
// Strided word reader for the InOut feature-map SRAM, streaming 16-bit words over valid/ready.
// Optional stall counter output enabled by defining SRAM_READER_PERF_EN.
module sram_stream_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 196608
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic [15:0] length,
  input  logic [7:0]  stride,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
`ifdef SRAM_READER_PERF_EN
  sp_ram_intf.master  mem,
  output logic [31:0] stall_cycles
`else
  sp_ram_intf.master  mem
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [17:0]   cur_addr;
  logic [15:0]   remaining;
  logic [7:0]    stride_q;
  logic          inflight;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [33:0]   end_addr;
  logic          range_bad, accept_start, credit_ok, issue, push, pop, oe_int;
  logic          unused_rdata_hi;

  // End address at full width so a long, wide-stride request can never alias into range.
  assign end_addr     = 34'(base_addr) + 34'(length - 16'd1) * 34'(stride);
  assign range_bad    = end_addr >= 34'(MEM_WORDS);
  assign accept_start = (state == IDLE) && start;

  // A read in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign credit_ok = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
  assign issue     = (state == READ) && (remaining != 16'd0) && credit_ok;
  assign push      = inflight;
  assign pop       = out_valid && out_ready;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 16'h0;

  assign mem.cs     = issue;
  assign mem.oe     = oe_int;
  assign mem.addr   = issue ? {14'b0, cur_addr} : 32'h0;
  assign mem.W_req  = 1'b1;
  assign mem.W_data = 32'h0;

  assign unused_rdata_hi = ^mem.R_data[31:16];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    oe_int    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (length == 16'd0 || range_bad) ? DONE : READ;
      end
      READ: begin
        busy   = 1'b1;
        oe_int = 1'b1;
        if (issue && remaining == 16'd1) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy   = 1'b1;
        oe_int = inflight;
        if (pop && count == CW'(1) && !inflight) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rstn) begin
      cur_addr  <= '0;
      remaining <= '0;
      stride_q  <= '0;
      err       <= 1'b0;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (accept_start) begin
        err       <= (length != 16'd0) && range_bad;
        cur_addr  <= base_addr;
        remaining <= length;
        stride_q  <= stride;
      end else if (issue) begin
        cur_addr  <= cur_addr + 18'(stride_q);
        remaining <= remaining - 16'd1;
      end
      inflight <= issue;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // NOTE: FIFO storage has no reset; out_valid gates its contents, and out_data is forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem.R_data[15:0];
  end

`ifdef SRAM_READER_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                                 stall_cycles <= '0;
    else if (accept_start)                                     stall_cycles <= '0;
    else if (busy && out_valid && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: directed table, hand sequences and random requests
// compared against an address/data model computed from base, length and stride.
module tb_sram_stream_reader;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_WORDS  = 196608;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [15:0] length = '0;
  logic [7:0]  stride = '0;
  logic        out_ready = 1'b0;
  logic        busy, done, err, out_valid;
  logic [15:0] out_data;
`ifdef SRAM_READER_PERF_EN
  logic [31:0] stall_cycles;
`endif

  sp_ram_intf mem_if ();

  sram_stream_reader #(.FIFO_DEPTH(FIFO_DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
    .stride(stride), .busy(busy), .done(done), .err(err), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready),
`ifdef SRAM_READER_PERF_EN
    .mem(mem_if), .stall_cycles(stall_cycles)
`else
    .mem(mem_if)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, sign-extended upper half, junk on idle cycles.
  logic [15:0] sram [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_if.cs && mem_if.addr < 32'(MEM_WORDS))
      mem_if.R_data <= {{16{sram[mem_if.addr[17:0]][15]}}, sram[mem_if.addr[17:0]]};
    else
      mem_if.R_data <= $urandom;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [17:0] base;
    logic [15:0] len;
    logic [7:0]  stride;
    int          stall_pct;
    int          hold;
    bit          mid_start;
    bit          exp_err;
    int          exp_reads;
    int          exp_pre_stall;
  } vec_t;

  task automatic run_txn(input vec_t v, input bit use_table);
    logic [17:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [17:0] got_addr[$];
    logic [15:0] got_data[$];
    longint      end_a;
    bit          m_err, legal, rdy, prev_cs, prev_stall, exp_oe;
    logic [15:0] prev_data;
    logic [17:0] a;
    int done_cyc, done_cnt, last_acc, last_iss, pre_stall, proto_bad, oe_bad, busy_bad, exp_stall, n;

    end_a = longint'(v.base) + (longint'(v.len) - 1) * longint'(v.stride);
    m_err = (v.len != 0) && (end_a >= MEM_WORDS);
    legal = (v.len != 0) && !m_err;
    if (legal)
      for (int i = 0; i < int'(v.len); i++) begin
        a = 18'(longint'(v.base) + longint'(i) * longint'(v.stride));
        exp_addr.push_back(a);
        exp_data.push_back(sram[a]);
      end

    @(negedge clk);
    base_addr = v.base; length = v.len; stride = v.stride; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    done_cyc = -1; done_cnt = 0; last_acc = -1; last_iss = -1; pre_stall = 0;
    proto_bad = 0; oe_bad = 0; busy_bad = 0; exp_stall = 0;
    prev_cs = 1'b0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (v.mid_start && cyc == 2) begin
        start = 1'b1; base_addr = 18'h2FFFF; length = 16'd5; stride = 8'd1;
      end else if (v.mid_start && cyc == 3) begin
        start = 1'b0;
      end
      if (mem_if.W_req !== 1'b1 || mem_if.W_data !== 32'h0) proto_bad++;
      exp_oe = legal && !done && (got_addr.size() < int'(v.len) || prev_cs);
      if (mem_if.oe !== exp_oe) oe_bad++;
      if (done ? (busy !== 1'b0) : (busy !== legal)) busy_bad++;
      if (mem_if.cs) begin
        if (mem_if.addr[31:18] !== 14'h0) proto_bad++;
        got_addr.push_back(mem_if.addr[17:0]);
        if (cyc < v.hold) pre_stall++;
        last_iss = cyc;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data)) proto_bad++;
      rdy = (cyc >= v.hold) && ($urandom_range(99) >= v.stall_pct);
      out_ready = rdy;
      if (out_valid && rdy) begin
        got_data.push_back(out_data);
        last_acc = cyc;
      end
      if (busy && out_valid && !rdy) exp_stall++;
      prev_stall = out_valid && !rdy;
      prev_data  = out_data;
      prev_cs    = mem_if.cs;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (mem_if.cs || busy || out_valid || mem_if.oe) proto_bad++;
    end
    out_ready = 1'b0;

    check("done_count", done_cnt, 1);
    check("err", err, use_table ? v.exp_err : m_err);
    if (use_table) check("reads_table", got_addr.size(), v.exp_reads);
    check("reads_model", got_addr.size(), exp_addr.size());
    check("words_model", got_data.size(), exp_data.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) check($sformatf("addr[%0d]", i), got_addr[i], exp_addr[i]);
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) check($sformatf("data[%0d]", i), got_data[i], exp_data[i]);
    check("protocol", proto_bad, 0);
    check("oe", oe_bad, 0);
    check("busy", busy_bad, 0);
    if (v.exp_pre_stall >= 0) check("issues_before_stall", pre_stall, v.exp_pre_stall);
    if (legal) begin
      check("done_after_last_accept", done_cyc, last_acc + 1);
      if (v.stall_pct == 0 && v.hold == 0) begin
        check("last_issue_cycle", last_iss, int'(v.len) - 1);
        check("done_cycle_stream", done_cyc, int'(v.len) + 2);
      end
    end else begin
      check("done_cycle_noaccess", done_cyc, 0);
    end
`ifdef SRAM_READER_PERF_EN
    check("stall_cycles", stall_cycles, exp_stall);
`endif
  endtask

  vec_t vecs[12];
  vec_t rv;
  int   acc, done_seen, cs_seen, valid_seen;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) sram[i] = 16'($urandom);
    sram[18'h10] = 16'h1111; sram[18'h11] = 16'h2222;
    sram[18'h12] = 16'h3333; sram[18'h13] = 16'h4444;

    //          base       len      stride  stall hold mid err reads pre
    vecs[0]  = '{18'h00010, 16'd4,     8'd1,   0,   0, 1'b0, 1'b0, 4,  -1};
    vecs[1]  = '{18'h07FFE, 16'd3,     8'd2,   0,   0, 1'b0, 1'b0, 3,  -1};
    vecs[2]  = '{18'h00100, 16'd8,     8'd1,   0,  10, 1'b0, 1'b0, 8,   4};
    vecs[3]  = '{18'h2FFFF, 16'd2,     8'd1,   0,   0, 1'b0, 1'b1, 0,  -1};
    vecs[4]  = '{18'h01234, 16'd0,     8'd5,   0,   0, 1'b0, 1'b0, 0,  -1};
    vecs[5]  = '{18'h2FFFF, 16'd1,     8'd1,   0,   0, 1'b0, 1'b0, 1,  -1};
    vecs[6]  = '{18'h00200, 16'd5,     8'd0,   0,   0, 1'b0, 1'b0, 5,  -1};
    vecs[7]  = '{18'h00040, 16'd6,     8'd3,   0,   0, 1'b1, 1'b0, 6,  -1};
    vecs[8]  = '{18'h2FF01, 16'd2,     8'd255, 0,   0, 1'b0, 1'b1, 0,  -1};
    vecs[9]  = '{18'h2FF00, 16'd2,     8'd255, 0,   0, 1'b0, 1'b0, 2,  -1};
    vecs[10] = '{18'h00000, 16'd65535, 8'd255, 0,   0, 1'b0, 1'b1, 0,  -1};
    vecs[11] = '{18'h00300, 16'd12,    8'd7,  40,   0, 1'b0, 1'b0, 12, -1};

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0);
    check("rst_cs", mem_if.cs, 1'b0);
    check("rst_oe", mem_if.oe, 1'b0);
    check("rst_w_req", mem_if.W_req, 1'b1);
    check("rst_addr", mem_if.addr, 32'h0);
    check("rst_w_data", mem_if.W_data, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) run_txn(vecs[i], 1'b1);

    // Reset pulled mid-burst while the third word is on the output.
    @(negedge clk);
    base_addr = 18'h00500; length = 16'd8; stride = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1; acc = 0;
    for (int cyc = 0; cyc < 50 && acc < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) acc++;
    end
    check("mid_reset_words_before", acc, 3);
    check("mid_reset_busy_before", busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("mid_reset_cs", mem_if.cs, 1'b0);
    check("mid_reset_oe", mem_if.oe, 1'b0);
    check("mid_reset_out_valid", out_valid, 1'b0);
    check("mid_reset_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    done_seen = 0; cs_seen = 0; valid_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
      if (mem_if.cs) cs_seen++;
      if (out_valid) valid_seen++;
    end
    out_ready = 1'b0;
    check("mid_reset_no_done", done_seen, 0);
    check("mid_reset_no_cs", cs_seen, 0);
    check("mid_reset_no_valid", valid_seen, 0);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(3) == 0) rv.base = 18'(MEM_WORDS - 1 - int'($urandom_range(300)));
      else                        rv.base = 18'($urandom_range(MEM_WORDS - 1));
      rv.len           = 16'($urandom_range(16));
      rv.stride        = ($urandom_range(2) == 0) ? 8'($urandom_range(4)) : 8'($urandom_range(255));
      rv.stall_pct     = int'($urandom_range(70));
      rv.hold          = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(8));
      rv.mid_start     = 1'b0;
      rv.exp_err       = 1'b0;
      rv.exp_reads     = 0;
      rv.exp_pre_stall = -1;
      run_txn(rv, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
